// File: rtl/reg_bank.sv
// ---------------------------------------------------------------------------
// reg_bank - MIPS multicycle general-purpose register file with A/B latches
//
// Purpose:
//   32 x 32-bit register array with two combinational read ports and one
//   write port. It also holds the A/B operand latches that feed the ALU
//   source muxes. Register 0 is hard-wired to zero. Register 29 (the stack
//   pointer) comes out of reset as 0x000000E3. Every other register comes
//   out of reset as zero.
//
// Optional feature:
//   `REGBANK_BYPASS_EN - when defined, a read port whose address matches an
//   active write (RegWrite=1, WriteReg!=0) returns WriteData in the same
//   cycle. The A/B latches then capture the bypassed value. When undefined,
//   the read ports return only the stored array contents.
//
// Ports:
//   clk        in  1  : rising-edge clock
//   reset      in  1  : synchronous active-high reset
//   RegWrite   in  1  : array write enable
//   ReadReg1   in  5  : read port 1 address (rs)
//   ReadReg2   in  5  : read port 2 address (rt)
//   WriteReg   in  5  : write address (rt, rd, 29 or 31)
//   WriteData  in  32 : write data
//   A_load     in  1  : operand latch A load enable
//   B_load     in  1  : operand latch B load enable
//   ReadData1  out 32 : combinational read, port 1
//   ReadData2  out 32 : combinational read, port 2
//   A_out      out 32 : registered operand A
//   B_out      out 32 : registered operand B
// ---------------------------------------------------------------------------
module reg_bank (
    input  logic        clk,
    input  logic        reset,
    input  logic        RegWrite,
    input  logic [4:0]  ReadReg1,
    input  logic [4:0]  ReadReg2,
    input  logic [4:0]  WriteReg,
    input  logic [31:0] WriteData,
    input  logic        A_load,
    input  logic        B_load,
    output logic [31:0] ReadData1,
    output logic [31:0] ReadData2,
    output logic [31:0] A_out,
    output logic [31:0] B_out
);

    localparam logic [31:0] SP_RESET  = 32'h0000_00E3;
    localparam logic [4:0]  SP_ADDR   = 5'd29;
    localparam logic [4:0]  ZERO_ADDR = 5'd0;

    logic [31:0] regs_r [0:31];
    logic [31:0] rd1_s;
    logic [31:0] rd2_s;
    logic [31:0] a_r;
    logic [31:0] b_r;
    logic        wr_en_s;

    // A write to r0 is dropped here, so the r0 storage never changes.
    assign wr_en_s = RegWrite && (WriteReg != ZERO_ADDR);

    // Register array: the reset image (SP preset, all else zero), then writes.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) begin
                if (5'(i) == SP_ADDR) begin
                    regs_r[i] <= SP_RESET;
                end else begin
                    regs_r[i] <= 32'h0000_0000;
                end
            end
        end else if (wr_en_s) begin
            regs_r[WriteReg] <= WriteData;
        end else begin
            regs_r[WriteReg] <= regs_r[WriteReg];
        end
    end

    // Read port 1: r0 forced to zero, optional same-cycle write bypass.
    always_comb begin
        rd1_s = 32'h0000_0000;
        if (ReadReg1 == ZERO_ADDR) begin
            rd1_s = 32'h0000_0000;
`ifdef REGBANK_BYPASS_EN
        end else if (wr_en_s && (ReadReg1 == WriteReg)) begin
            rd1_s = WriteData;
`endif
        end else begin
            rd1_s = regs_r[ReadReg1];
        end
    end

    // Read port 2: same rules as port 1.
    always_comb begin
        rd2_s = 32'h0000_0000;
        if (ReadReg2 == ZERO_ADDR) begin
            rd2_s = 32'h0000_0000;
`ifdef REGBANK_BYPASS_EN
        end else if (wr_en_s && (ReadReg2 == WriteReg)) begin
            rd2_s = WriteData;
`endif
        end else begin
            rd2_s = regs_r[ReadReg2];
        end
    end

    // Operand latches capture the read-port value (bypassed if enabled).
    always_ff @(posedge clk) begin
        if (reset) begin
            a_r <= 32'h0000_0000;
            b_r <= 32'h0000_0000;
        end else begin
            if (A_load) begin
                a_r <= rd1_s;
            end else begin
                a_r <= a_r;
            end
            if (B_load) begin
                b_r <= rd2_s;
            end else begin
                b_r <= b_r;
            end
        end
    end

    assign ReadData1 = rd1_s;
    assign ReadData2 = rd2_s;
    assign A_out     = a_r;
    assign B_out     = b_r;

endmodule

// File: tb/tb_reg_bank.sv
// ---------------------------------------------------------------------------
// tb_reg_bank - self-checking bench for reg_bank.
// A plain array model tracks the architectural register state and the A/B
// latches. One compare process checks every output on each falling edge.
// Directed scenarios with literal expectations pin the model first. After
// that, randomized traffic runs against the model.
// ---------------------------------------------------------------------------
module tb_reg_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic        A_load;
    logic        B_load;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic [31:0] A_out;
    logic [31:0] B_out;

    int errors = 0;
    int checks = 0;
    bit started = 1'b0;

`ifdef REGBANK_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    // Reference state
    logic [31:0] m_regs [32];
    logic [31:0] m_a;
    logic [31:0] m_b;

    reg_bank dut (
        .clk       (clk),
        .reset     (reset),
        .RegWrite  (RegWrite),
        .ReadReg1  (ReadReg1),
        .ReadReg2  (ReadReg2),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .A_load    (A_load),
        .B_load    (B_load),
        .ReadData1 (ReadData1),
        .ReadData2 (ReadData2),
        .A_out     (A_out),
        .B_out     (B_out)
    );

    always #5 clk = ~clk;

    // Value a read port must return for a given address and write-port state.
    function automatic logic [31:0] mread(input logic [4:0] addr, input logic we,
                                          input logic [4:0] wa, input logic [31:0] wd);
        if (addr == 5'd0) return 32'd0;
        if (BYPASS && we && addr == wa) return wd;
        return m_regs[addr];
    endfunction

    // Model update at each rising edge, using the inputs held across that edge.
    always @(posedge clk) begin
        logic [31:0] ra, rb;
        ra = mread(ReadReg1, RegWrite, WriteReg, WriteData);
        rb = mread(ReadReg2, RegWrite, WriteReg, WriteData);
        if (reset) begin
            for (int i = 0; i < 32; i++) m_regs[i] = (i == 29) ? 32'd227 : 32'd0;
            m_a = 32'd0;
            m_b = 32'd0;
        end else begin
            if (A_load) m_a = ra;
            if (B_load) m_b = rb;
            if (RegWrite && WriteReg != 5'd0) m_regs[WriteReg] = WriteData;
        end
    end

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%08h expected=%08h at %0t", name, got, exp, $time);
        end
    endtask

    // Compare process: every output against the model on each falling edge.
    always @(negedge clk) begin
        if (started) begin
            cmp("rd1", ReadData1, mread(ReadReg1, RegWrite, WriteReg, WriteData));
            cmp("rd2", ReadData2, mread(ReadReg2, RegWrite, WriteReg, WriteData));
            cmp("a_out", A_out, m_a);
            cmp("b_out", B_out, m_b);
        end
    end

    task automatic drive(input logic rst, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2,
                         input logic al, input logic bl);
        reset = rst; RegWrite = we; WriteReg = wa; WriteData = wd;
        ReadReg1 = r1; ReadReg2 = r2; A_load = al; B_load = bl;
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic mid();
        @(negedge clk);
        #1;
    endtask

    initial begin
        drive(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd29, 1'b0, 1'b0);
        step();
        started = 1'b1;

        // Reset values
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd29, 5'd31, 1'b0, 1'b0);
        mid();
        cmp("lit_rst_r29", ReadData1, 32'd227);
        cmp("lit_rst_r31", ReadData2, 32'd0);
        cmp("lit_rst_a", A_out, 32'd0);
        cmp("lit_rst_b", B_out, 32'd0);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        mid();
        cmp("lit_rst_r0", ReadData1, 32'd0);
        step();

        // Basic write/read and r0 immunity
        drive(1'b0, 1'b1, 5'd8, 32'hDEADBEEF, 5'd0, 5'd0, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd8, 5'd0, 1'b0, 1'b0);
        mid();
        cmp("lit_r8", ReadData1, 32'hDEADBEEF);
        step();
        drive(1'b0, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        mid();
        cmp("lit_r0_write", ReadData1, 32'd0);
        step();

        // Stack pointer and link register
        drive(1'b0, 1'b1, 5'd29, 32'h00000100, 5'd0, 5'd0, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b1, 5'd31, 32'h00000040, 5'd0, 5'd0, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd29, 5'd31, 1'b0, 1'b0);
        mid();
        cmp("lit_sp", ReadData1, 32'h00000100);
        cmp("lit_ra", ReadData2, 32'h00000040);
        step();

        // Operand latches load and hold
        drive(1'b0, 1'b1, 5'd5, 32'd7, 5'd0, 5'd0, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b1, 5'd6, 32'd9, 5'd0, 5'd0, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd6, 1'b1, 1'b1);
        step();
        drive(1'b0, 1'b1, 5'd5, 32'd3, 5'd5, 5'd6, 1'b0, 1'b0);
        mid();
        cmp("lit_a7", A_out, 32'd7);
        cmp("lit_b9", B_out, 32'd9);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0, 1'b0, 1'b0);
        mid();
        cmp("lit_a_hold", A_out, 32'd7);
        cmp("lit_r5_new", ReadData1, 32'd3);
        step();

        // Same-edge write and load on one register
        drive(1'b0, 1'b1, 5'd10, 32'd1, 5'd0, 5'd0, 1'b0, 1'b0);
        step();
        drive(1'b0, 1'b1, 5'd10, 32'd2, 5'd10, 5'd0, 1'b1, 1'b0);
        mid();
        cmp("lit_coll_rd1", ReadData1, BYPASS ? 32'd2 : 32'd1);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd10, 5'd0, 1'b0, 1'b0);
        mid();
        cmp("lit_coll_a", A_out, BYPASS ? 32'd2 : 32'd1);
        cmp("lit_coll_r10", ReadData1, 32'd2);
        step();

        // Reset wins over write and load
        drive(1'b1, 1'b1, 5'd29, 32'hFFFFFFFF, 5'd29, 5'd0, 1'b1, 1'b0);
        step();
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd29, 5'd10, 1'b0, 1'b0);
        mid();
        cmp("lit_rp_r29", ReadData1, 32'd227);
        cmp("lit_rp_r10", ReadData2, 32'd0);
        cmp("lit_rp_a", A_out, 32'd0);
        step();

        // Randomized traffic, biased toward read/write address collisions
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] wa, r1, r2;
            wa = 5'($urandom_range(31, 0));
            r1 = ($urandom_range(3, 0) == 0) ? wa : 5'($urandom_range(31, 0));
            r2 = ($urandom_range(3, 0) == 0) ? wa : 5'($urandom_range(31, 0));
            drive(($urandom_range(99, 0) == 0), 1'($urandom_range(1, 0)), wa, $urandom,
                  r1, r2, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
            step();
        end
        drive(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 1'b0, 1'b0);
        mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
